// File: rtl/button_event_arbiter.sv
// Debounces NUM_BTN raw buttons on a shared sample tick, generates auto-repeat,
// and serialises press/release/repeat events round-robin onto one valid/ready channel.
`timescale 1ns/1ps
module button_event_arbiter #(
  parameter int NUM_BTN      = 4,
  parameter int TICK_POW     = 16,
  parameter int STABLE_TICKS = 4,
  parameter int REPEAT_DELAY = 32,
  parameter int REPEAT_RATE  = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [NUM_BTN-1:0]         in,
  output logic [NUM_BTN-1:0]         state_o,
  output logic                       ev_valid_o,
  input  logic                       ev_ready_i,
  output logic [$clog2(NUM_BTN)-1:0] ev_btn_o,
  output logic [1:0]                 ev_type_o,
  output logic                       overflow_o,
  input  logic                       clr_ovf_i
);

  localparam int BTN_W = $clog2(NUM_BTN);
  localparam logic [3:0]       STAB_LAST = 4'(STABLE_TICKS - 1);
  localparam logic [7:0]       DELAY_TH  = 8'(REPEAT_DELAY);
  localparam logic [7:0]       RATE_TH   = 8'(REPEAT_RATE);
  localparam logic [BTN_W-1:0] BTN_LAST  = BTN_W'(NUM_BTN - 1);
  localparam logic [BTN_W:0]   BTN_NUM   = (BTN_W+1)'(NUM_BTN);

  typedef enum logic [1:0] {
    EV_PRESS   = 2'b00,
    EV_RELEASE = 2'b01,
    EV_REPEAT  = 2'b10
  } ev_type_e;

  typedef enum logic {
    S_IDLE,
    S_OFFER
  } arb_state_e;

  // Input synchroniser and shared sample prescaler
  logic [NUM_BTN-1:0]  sync1_q, sync2_q;
  logic [TICK_POW-1:0] presc_q;
  logic                tick;

  // Per-button filter and auto-repeat state
  logic [NUM_BTN-1:0]      state_q, state_d;
  logic [NUM_BTN-1:0][3:0] stab_q, stab_d;
  logic [NUM_BTN-1:0][7:0] rep_q, rep_d;
  logic [NUM_BTN-1:0]      later_q, later_d;
  logic [NUM_BTN-1:0]      flip;
  logic [NUM_BTN-1:0][7:0] rep_inc;

  // Pending event flags
  logic [NUM_BTN-1:0] set_press, set_rel, set_rep;
  logic [NUM_BTN-1:0] clr_press, clr_rel, clr_rep;
  logic [NUM_BTN-1:0] press_pend_q, rel_pend_q, rep_pend_q;
  logic [NUM_BTN-1:0] pend_any, ovf_hit;
  logic               ovf_q;

  // Output arbiter
  arb_state_e       arb_q, arb_d;
  logic [BTN_W-1:0] rr_q, rr_d;
  logic [BTN_W-1:0] btn_q, btn_d;
  ev_type_e         type_q, type_d;
  logic             handshake;
  logic             found;
  logic [BTN_W:0]   scan_sum;
  logic [BTN_W-1:0] cand;

  // NOTE: sequential state always uses non-blocking assignments, so every flop
  // samples the pre-edge value and the two sync stages shift instead of collapsing.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= '0;
      sync2_q <= '0;
      presc_q <= '0;
    end else begin
      sync1_q <= in;
      sync2_q <= sync1_q;
      presc_q <= presc_q + TICK_POW'(1);
    end
  end

  assign tick = &presc_q;

  // NOTE: every variable driven here gets a default first, so no branch can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    stab_d    = stab_q;
    rep_d     = rep_q;
    later_d   = later_q;
    flip      = '0;
    rep_inc   = '0;
    set_press = '0;
    set_rel   = '0;
    set_rep   = '0;
    if (tick) begin
      for (int i = 0; i < NUM_BTN; i++) begin
        if (sync2_q[i] != state_q[i]) begin
          if (stab_q[i] == STAB_LAST) begin
            flip[i]      = 1'b1;
            state_d[i]   = ~state_q[i];
            stab_d[i]    = '0;
            set_press[i] = ~state_q[i];
            set_rel[i]   = state_q[i];
          end else begin
            stab_d[i] = stab_q[i] + 4'd1;
          end
        end else begin
          stab_d[i] = '0;
        end

        // "later" selects the repeat-rate threshold once the first repeat has fired
        rep_inc[i] = rep_q[i] + 8'd1;
        if (flip[i] || !state_q[i]) begin
          rep_d[i]   = '0;
          later_d[i] = 1'b0;
        end else if (rep_inc[i] == (later_q[i] ? RATE_TH : DELAY_TH)) begin
          set_rep[i] = 1'b1;
          rep_d[i]   = '0;
          later_d[i] = 1'b1;
        end else begin
          rep_d[i] = rep_inc[i];
        end
      end
    end
  end

  assign handshake = (arb_q == S_OFFER) && ev_ready_i;

  always_comb begin
    clr_press = '0;
    clr_rel   = '0;
    clr_rep   = '0;
    if (handshake) begin
      case (type_q)
        EV_PRESS:   clr_press[btn_q] = 1'b1;
        EV_RELEASE: clr_rel[btn_q]   = 1'b1;
        EV_REPEAT:  clr_rep[btn_q]   = 1'b1;
        default:    ;
      endcase
    end
  end

  // A flag that is re-set while still pending (and not being consumed) means a lost event
  assign ovf_hit = (set_press & press_pend_q & ~clr_press)
                 | (set_rel   & rel_pend_q   & ~clr_rel)
                 | (set_rep   & rep_pend_q   & ~clr_rep);

  assign pend_any = press_pend_q | rel_pend_q | rep_pend_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= '0;
      stab_q       <= '0;
      rep_q        <= '0;
      later_q      <= '0;
      press_pend_q <= '0;
      rel_pend_q   <= '0;
      rep_pend_q   <= '0;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      stab_q       <= stab_d;
      rep_q        <= rep_d;
      later_q      <= later_d;
      press_pend_q <= (press_pend_q & ~clr_press) | set_press;
      rel_pend_q   <= (rel_pend_q & ~clr_rel) | set_rel;
      // A new release makes any outstanding repeat stale, so it is dropped silently
      rep_pend_q   <= (rep_pend_q & ~clr_rep & ~set_rel) | set_rep;
      if (|ovf_hit) begin
        ovf_q <= 1'b1;
      end else if (clr_ovf_i) begin
        ovf_q <= 1'b0;
      end
    end
  end

  always_comb begin
    arb_d    = arb_q;
    rr_d     = rr_q;
    btn_d    = btn_q;
    type_d   = type_q;
    found    = 1'b0;
    scan_sum = '0;
    cand     = '0;
    case (arb_q)
      S_IDLE: begin
        for (int k = 0; k < NUM_BTN; k++) begin
          scan_sum = {1'b0, rr_q} + (BTN_W+1)'(k);
          if (scan_sum >= BTN_NUM) begin
            scan_sum = scan_sum - BTN_NUM;
          end
          cand = scan_sum[BTN_W-1:0];
          if (!found && pend_any[cand]) begin
            found = 1'b1;
            btn_d = cand;
            if (press_pend_q[cand]) begin
              type_d = EV_PRESS;
            end else if (rel_pend_q[cand]) begin
              type_d = EV_RELEASE;
            end else begin
              type_d = EV_REPEAT;
            end
          end
        end
        if (found) begin
          arb_d = S_OFFER;
        end
      end
      S_OFFER: begin
        if (ev_ready_i) begin
          arb_d = S_IDLE;
          rr_d  = (btn_q == BTN_LAST) ? '0 : btn_q + BTN_W'(1);
        end
      end
      default: arb_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      arb_q  <= S_IDLE;
      rr_q   <= '0;
      btn_q  <= '0;
      type_q <= EV_PRESS;
    end else begin
      arb_q  <= arb_d;
      rr_q   <= rr_d;
      btn_q  <= btn_d;
      type_q <= type_d;
    end
  end

  assign state_o    = state_q;
  assign ev_valid_o = (arb_q == S_OFFER);
  assign ev_btn_o   = btn_q;
  assign ev_type_o  = type_q;
  assign overflow_o = ovf_q;

endmodule

// File: doc/button_event_arbiter.md
Name: button_event_arbiter

Overview:
Multi-button front-end controller that sequences debounce sampling for NUM_BTN raw inputs and shares one event output between them. A single shared prescaler sets the sample tick for every button. Each button gets a stable-sample filter and an auto-repeat timer. A round-robin arbiter serialises press, release and repeat events onto one valid/ready channel for a CPU peripheral or UART reporter.

Parameters:
NUM_BTN, 4, number of button inputs (2..16)
TICK_POW, 16, sample tick period is 2^TICK_POW clk_i cycles
STABLE_TICKS, 4, consecutive differing samples needed to flip debounced state (2..15)
REPEAT_DELAY, 32, ticks a button must be held before the first repeat event (1..255)
REPEAT_RATE, 8, ticks between later repeat events (1..255)

Ports:
clk_i  input  1  clock
rst_i  input  1  asynchronous active-high reset
in  input  NUM_BTN  raw asynchronous button levels, 1 = pressed
state_o  output  NUM_BTN  debounced button levels
ev_valid_o  output  1  event available
ev_ready_i  input  1  consumer accepts event
ev_btn_o  output  $clog2(NUM_BTN)  button index of event
ev_type_o  output  2  00 press, 01 release, 10 repeat
overflow_o  output  1  sticky lost-event flag
clr_ovf_i  input  1  clears overflow_o

Behaviour:
- Reset (async, rst_i=1): all registers clear immediately. state_o=0, ev_valid_o=0, ev_btn_o=0, ev_type_o=00, overflow_o=0, all pending flags, counters and the round-robin pointer = 0.
- Synchroniser: in passes through 2 flops per bit. Filters use only the synchronised value.
- Prescaler: TICK_POW-bit free-running counter, wraps naturally. tick=1 for one cycle when the counter is all ones.
- Filter, per button, evaluated only on tick:
  - Sample differs from state_o[i]: stab_cnt increments.
  - If stab_cnt == STABLE_TICKS-1 while differing: state_o[i] toggles, stab_cnt clears, press_pend (0->1) or rel_pend (1->0) sets.
  - Sample equals state_o[i]: stab_cnt clears.
  - Minimum latency from in change to state_o change = 2 sync cycles + STABLE_TICKS ticks.
- Auto-repeat, per button, 8-bit rep_cnt, advanced on tick:
  - Cleared on any state change or while released.
  - While pressed, counts up. On reaching REPEAT_DELAY (first repeat) or REPEAT_RATE (later repeats): rep_pend sets and rep_cnt reloads to 0. A per-button "first" bit selects the threshold.
- Pending flags: 3 per button, set-only by the filter/repeat logic, cleared only on handshake.
  - Setting a flag that is already set, in a cycle where it is not being consumed, sets overflow_o.
  - overflow_o clears on clr_ovf_i; a set in the same cycle wins.
- Priority within a button:
  - press before release, so the order of real edges is preserved.
  - Repeat has lowest priority.
  - A pending repeat is discarded, without overflow, when release becomes pending.
- Output FSM:
  - IDLE: on any pending flag, choose the first button with pending flags, starting at rr_ptr and scanning upward with wrap. Register index and type, go to OFFER with ev_valid_o=1. One cycle latency from flag set to ev_valid_o.
  - OFFER: ev_btn_o and ev_type_o are held stable while ev_valid_o=1 and ev_ready_i=0.
  - OFFER handshake (ev_valid_o & ev_ready_i): the corresponding pending flag clears, rr_ptr = granted index + 1 (wraps to 0 past NUM_BTN-1), return to IDLE. No back-to-back issue; at most one event per 2 cycles.
- Simultaneous events:
  - A flag set in the same cycle its earlier instance is consumed stays set, with no overflow.
  - Multiple buttons changing on the same tick all record pending flags. The arbiter drains them in round-robin order.
- Mid-operation reset aborts any offered event; the event is lost.

Test Plan:
- Reset mid-OFFER: assert rst_i between clock edges while ev_valid_o=1 -> ev_valid_o, state_o and overflow_o go to 0 without waiting for a clock edge.
- Clean press/release: TICK_POW=4, STABLE_TICKS=4, in[2] held 1 for 200 cycles then 0 -> press event (btn 2, type 00) then release event (btn 2, type 01). state_o[2] rises 2+4 ticks after the edge.
- Bounce rejection: in[1] toggling every 20 cycles (longer than one tick, shorter than 4 ticks) -> no events, state_o[1]=0, overflow_o=0.
- Auto-repeat: REPEAT_DELAY=3, REPEAT_RATE=2, hold in[0] with ev_ready_i=1 -> press, repeat at 3 ticks, then a repeat every 2 ticks; release -> release event, no trailing repeat.
- Round-robin and backpressure: in[0], in[1] and in[3] pressed on the same tick with ev_ready_i=0 for 50 cycles -> ev_btn_o holds 0 stable. Then ready=1 -> order 0, 1, 3.
- Overflow: press and release in[0] twice while ev_ready_i=0 -> overflow_o=1 and stays set. After clr_ovf_i pulse -> overflow_o=0.
